// File: rtl/uart_tx_if.sv
// uart_tx_if: write-request handshake between a core and the UART transmitter.
//   arg : {valid, data[7:0]} write request, driven by the core (master)
//   out : ready, driven by the transmitter (slave); a byte is taken at a
//         clock edge where valid and ready are both high
interface uart_tx_if;
    logic [8:0] arg;
    logic       out;

    modport master (output arg, input  out);
    modport slave  (input  arg, output out);
endinterface

// File: rtl/uart_tx.sv
// uart_tx: FIFO-buffered 8N1 UART transmitter.
//   CLK   : single clock, all state changes on its rising edge
//   RST_N : synchronous active-low reset (clears FIFO, aborts any frame)
//   wr    : uart_tx_if.slave, {valid,data} request in / ready out
//   tx    : registered serial line, idle high
//   busy  : FIFO non-empty or a frame in flight
// A byte pushed into an empty FIFO starts its start bit two edges later;
// a queued byte is loaded on the last stop-bit cycle so frames go out
// back-to-back with no idle gap.
module uart_tx #(
    parameter int CLKS_PER_BIT = 104,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic     CLK,
    input  logic     RST_N,
    uart_tx_if.slave wr,
    output logic     tx,
    output logic     busy
);

    localparam int              AW       = $clog2(FIFO_DEPTH);
    localparam logic [AW-1:0]   PTR_ONE  = AW'(1);
    localparam logic [AW:0]     CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]     CNT_FULL = (AW+1)'(FIFO_DEPTH);
    localparam logic [15:0]     BAUD_MAX = 16'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t        state_r;
    state_t        state_next_s;
    logic [7:0]    fifo_mem_r [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   count_r;
    logic [15:0]   baud_cnt_r;
    logic [15:0]   baud_next_s;
    logic [2:0]    bit_idx_r;
    logic [2:0]    bit_idx_next_s;
    logic [7:0]    shift_r;
    logic [7:0]    shift_next_s;
    logic          tx_r;
    logic          tx_next_s;
    logic          ready_s;
    logic          push_s;
    logic          pop_s;
    logic          empty_s;
    logic          bit_done_s;

    // Ready depends only on reset and FIFO occupancy, never on valid.
    assign ready_s    = RST_N && (count_r != CNT_FULL);
    assign push_s     = wr.arg[8] && ready_s;
    assign empty_s    = (count_r == '0);
    assign bit_done_s = (baud_cnt_r == BAUD_MAX);
    assign wr.out     = ready_s;
    assign tx         = tx_r;
    assign busy       = (state_r != IDLE) || !empty_s;

    // FSM state register.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (!empty_s) state_next_s = START;
                else          state_next_s = IDLE;
            end
            START: begin
                if (bit_done_s) state_next_s = DATA;
                else            state_next_s = START;
            end
            DATA: begin
                if (bit_done_s && (bit_idx_r == 3'd7)) state_next_s = STOP;
                else                                   state_next_s = DATA;
            end
            STOP: begin
                if (bit_done_s) begin
                    if (!empty_s) state_next_s = START;
                    else          state_next_s = IDLE;
                end else begin
                    state_next_s = STOP;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // FSM outputs: pop, baud/bit counters, shifter load and next line level.
    // The line level is derived from the next state so tx is registered yet
    // changes on the same edge as the state.
    always_comb begin
        pop_s          = (state_next_s == START) && ((state_r == IDLE) || (state_r == STOP));
        bit_idx_next_s = bit_idx_r;
        shift_next_s   = shift_r;
        tx_next_s      = 1'b1;

        if ((state_r == IDLE) || bit_done_s) baud_next_s = 16'd0;
        else                                 baud_next_s = baud_cnt_r + 16'd1;

        // Index wraps 7 -> 0 at the end of the data phase, ready for the next frame.
        if ((state_r == DATA) && bit_done_s) bit_idx_next_s = bit_idx_r + 3'd1;
        else                                 bit_idx_next_s = bit_idx_r;

        if (pop_s) shift_next_s = fifo_mem_r[rd_ptr_r];
        else       shift_next_s = shift_r;

        case (state_next_s)
            IDLE:    tx_next_s = 1'b1;
            START:   tx_next_s = 1'b0;
            DATA:    tx_next_s = shift_next_s[bit_idx_next_s];
            STOP:    tx_next_s = 1'b1;
            default: tx_next_s = 1'b1;
        endcase
    end

    // Transmit datapath registers.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            baud_cnt_r <= 16'd0;
            bit_idx_r  <= 3'd0;
            shift_r    <= 8'd0;
            tx_r       <= 1'b1;
        end else begin
            baud_cnt_r <= baud_next_s;
            bit_idx_r  <= bit_idx_next_s;
            shift_r    <= shift_next_s;
            tx_r       <= tx_next_s;
        end
    end

    // FIFO pointers and occupancy; simultaneous push/pop keeps the count.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
            if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // FIFO storage; contents need no reset since the count guards reads.
    always_ff @(posedge CLK) begin
        if (push_s) fifo_mem_r[wr_ptr_r] <= wr.arg[7:0];
    end

endmodule

// File: tb/tb_uart_tx.sv
module tb_uart_tx;
    localparam int CPB   = 4;
    localparam int DEPTH = 4;

    logic clk;
    logic rst_n;
    logic tx;
    logic busy;
    uart_tx_if u_if ();

    uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .CLK  (clk),
        .RST_N(rst_n),
        .wr   (u_if.slave),
        .tx   (tx),
        .busy (busy)
    );

    int n_chk = 0;
    int n_err = 0;

    // Behavioural model: queue of waiting bytes plus the frame in flight,
    // described by its byte and the number of cycles since its start bit began.
    logic [7:0] m_q[$];
    bit         m_active = 1'b0;
    int         m_off = 0;
    logic [7:0] m_byte = 8'h00;
    bit         m_acc = 1'b0;
    int         m_acc_cnt = 0;
    int         hs_dut = 0;
    bit         chk_en = 1'b0;

    // Simple receiver sampling mid-bit.
    bit         d_in = 1'b0;
    bit         d_prev = 1'b1;
    int         d_cnt = 0;
    logic [7:0] d_byte = 8'h00;
    logic [7:0] rx_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic model_tx();
        int slot;
        if (!m_active) return 1'b1;
        slot = m_off / CPB;
        if (slot == 0) return 1'b0;
        if (slot <= 8) return m_byte[slot-1];
        return 1'b1;
    endfunction

    // Model update at each active edge.
    always @(posedge clk) begin
        m_acc = 1'b0;
        if (!rst_n) begin
            m_q.delete();
            m_active = 1'b0;
            m_off = 0;
            chk_en = 1'b1;
        end else begin
            m_acc = u_if.arg[8] && (m_q.size() < DEPTH);
            if (m_active) begin
                if (m_off == 10*CPB - 1) begin
                    if (m_q.size() != 0) begin
                        m_byte = m_q.pop_front();
                        m_off = 0;
                    end else begin
                        m_active = 1'b0;
                    end
                end else begin
                    m_off++;
                end
            end else if (m_q.size() != 0) begin
                m_byte = m_q.pop_front();
                m_active = 1'b1;
                m_off = 0;
            end
            if (m_acc) begin
                m_q.push_back(u_if.arg[7:0]);
                m_acc_cnt++;
            end
        end
    end

    // Handshakes as seen on the DUT pins.
    always @(posedge clk) begin
        if (rst_n && u_if.arg[8] && u_if.out) hs_dut++;
    end

    // Per-cycle compare against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("tx", tx, model_tx());
            check("busy", busy, (m_active || m_q.size() != 0));
            check("ready", u_if.out, (rst_n && m_q.size() < DEPTH));
        end
    end

    // Receiver: start on a falling edge, sample bit centres.
    always @(negedge clk) begin
        if (!rst_n) begin
            d_in = 1'b0;
            d_prev = 1'b1;
        end else begin
            if (!d_in) begin
                if (d_prev && !tx) begin
                    d_in = 1'b1;
                    d_cnt = 0;
                end
            end else begin
                d_cnt++;
                if ((d_cnt % CPB == 2) && (d_cnt / CPB >= 1) && (d_cnt / CPB <= 8))
                    d_byte[d_cnt/CPB - 1] = tx;
                if (d_cnt == 9*CPB + 2) begin
                    check("stop_bit", tx, 1'b1);
                    rx_q.push_back(d_byte);
                    d_in = 1'b0;
                end
            end
            d_prev = tx;
        end
    end

    // Push n bytes first, first+1, ...; mode 0 = valid held, 1 = random gaps,
    // 2 = valid random only while the FIFO is full.
    task automatic push_seq(input int n, input int first, input int mode);
        int idx = 0;
        int guard = 0;
        bit v;
        while (idx < n && guard < 5000) begin
            case (mode)
                0:       v = 1'b1;
                1:       v = ($urandom_range(0, 3) != 0);
                default: v = (m_q.size() == DEPTH) ? ($urandom_range(0, 1) == 1) : 1'b1;
            endcase
            u_if.arg = {v, 8'(first + idx)};
            @(posedge clk); #1;
            if (m_acc) idx++;
            guard++;
        end
        u_if.arg = 9'h000;
        check("push_done", idx, n);
    endtask

    task automatic drain();
        int g = 0;
        while ((m_active || m_q.size() != 0) && g < 3000) begin
            @(posedge clk); #1;
            g++;
        end
        check("drain", 32'(m_active || m_q.size() != 0), 32'd0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic check_rx(input int first, input int n);
        check("rx_count", rx_q.size(), n);
        for (int i = 0; i < n && i < rx_q.size(); i++)
            check("rx_byte", rx_q[i], 8'(first + i));
    endtask

    initial begin
        logic [9:0] frame55;
        frame55 = 10'b1010101010;   // start, 1,0,1,0,1,0,1,0 (LSB first), stop
        rst_n = 1'b0;
        u_if.arg = 9'h000;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_ready", u_if.out, 1'b1);
        check("rst_tx", tx, 1'b1);
        check("rst_busy", busy, 1'b0);

        // Single byte 0x55 with literal timing.
        rx_q.delete();
        push_seq(1, 8'h55, 0);
        for (int i = 0; i <= 41; i++) begin
            @(negedge clk);
            if (i == 0) begin
                check("b55_pre_tx", tx, 1'b1);
                check("b55_pre_busy", busy, 1'b1);
            end else if (i <= 40) begin
                check("b55_tx", tx, frame55[(i-1)/CPB]);
            end else begin
                check("b55_end_tx", tx, 1'b1);
                check("b55_end_busy", busy, 1'b0);
            end
        end
        drain();
        check_rx(8'h55, 1);

        // Back-to-back 'A','B': second start bit 40 cycles after the first.
        rx_q.delete();
        push_seq(2, 8'h41, 0);
        for (int i = 0; i <= 40; i++) begin
            @(negedge clk);
            if (i == 0)  check("ab_start1", tx, 1'b0);
            if (i == 39) check("ab_stop1", tx, 1'b1);
            if (i == 40) check("ab_start2", tx, 1'b0);
        end
        drain();
        check_rx(8'h41, 2);

        // Full FIFO: 1 in shifter + 4 queued, then random valid while full.
        rx_q.delete();
        push_seq(5, 8'h01, 2);
        @(negedge clk);
        check("full_ready", u_if.out, 1'b0);
        check("full_model_q", m_q.size(), DEPTH);
        push_seq(3, 8'h06, 2);
        drain();
        check_rx(8'h01, 8);
        check("handshakes", hs_dut, m_acc_cnt);

        // Mid-frame reset during DATA of 0xA5 with two bytes queued.
        rx_q.delete();
        push_seq(3, 8'hA5, 0);
        repeat (6) @(posedge clk);
        #1;
        rst_n = 1'b0;
        u_if.arg = 9'h177;
        @(posedge clk); #1;
        rst_n = 1'b1;
        u_if.arg = 9'h000;
        @(negedge clk);
        check("mrst_tx", tx, 1'b1);
        check("mrst_busy", busy, 1'b0);
        check("mrst_ready", u_if.out, 1'b1);
        repeat (60) @(negedge clk);
        check("mrst_busy_late", busy, 1'b0);
        check("mrst_no_frames", rx_q.size(), 0);

        // Wrap-around: 64 bytes with random gaps.
        @(posedge clk); #1;
        rx_q.delete();
        push_seq(64, 8'h00, 1);
        drain();
        check_rx(8'h00, 64);
        check("handshakes_end", hs_dut, m_acc_cnt);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 104, SHALL set clock cycles per serial bit; legal range 2..65535.
REQ-002 Parameter FIFO_DEPTH, default 4, SHALL set transmit FIFO entries; power of two, 2..16.
REQ-003 CLK  input  1  single clock; all state updates on posedge CLK.
REQ-004 RST_N  input  1  reset, synchronous, active-low.
REQ-005 arg  input  9  {valid, data[7:0]}: the core's UART write request.
REQ-006 out  output  1  ready: the byte on arg is accepted at this edge when valid=1.
REQ-007 tx  output  1  serial line, 8N1, idle high, registered.
REQ-008 busy  output  1  high while the FIFO is non-empty or a frame is in flight.

Function
REQ-009 Accept: at posedge with valid=1 and ready=1, data SHALL be pushed to the FIFO tail.
REQ-010 ready SHALL be combinational from state only (never from valid): ready = RST_N and FIFO not full.
REQ-011 valid=1 with ready=0 SHALL have no effect; the core retries, no byte is dropped or duplicated.
REQ-012 FIFO SHALL be first-in first-out; pointers wrap modulo FIFO_DEPTH; count occupies log2(FIFO_DEPTH)+1 bits.
REQ-013 Simultaneous push and pop in one cycle SHALL leave count unchanged and preserve order.
REQ-014 FSM states SHALL be IDLE, START, DATA, STOP.
REQ-015 IDLE with FIFO non-empty SHALL pop the head into a shift register and enter START; tx=0 from the next cycle.
REQ-016 A push into an empty FIFO at edge N SHALL drive tx=0 after edge N+1, giving 2-cycle accept-to-start-bit latency.
REQ-017 START SHALL hold tx=0 for CLKS_PER_BIT cycles, then enter DATA.
REQ-018 DATA SHALL send 8 bits LSB first, each for CLKS_PER_BIT cycles, using a 3-bit bit index, then enter STOP.
REQ-019 STOP SHALL hold tx=1 for CLKS_PER_BIT cycles.
REQ-020 On the last STOP cycle with FIFO non-empty, the FSM SHALL pop and enter START directly, with no idle gap; back-to-back frames are exactly 10*CLKS_PER_BIT cycles apart.
REQ-021 On the last STOP cycle with FIFO empty, the FSM SHALL enter IDLE with tx=1.
REQ-022 The baud counter SHALL count 0..CLKS_PER_BIT-1, reload on every bit boundary, and be wide enough for 65535.
REQ-023 busy SHALL be high iff state is not IDLE or FIFO count is non-zero, computed from registered state.
REQ-024 Pushes SHALL continue to be accepted during frame transmission whenever the FIFO is not full.

Reset
REQ-025 RST_N low at a posedge SHALL clear the FIFO (count=0, pointers=0), set state IDLE, clear the baud counter and bit index, and set tx=1.
REQ-026 While RST_N is low, out (ready) SHALL be 0 and pushes SHALL be ignored.
REQ-027 A reset mid-frame SHALL abort the frame: tx=1 after that edge, with no partial bits afterwards and FIFO contents discarded.
REQ-028 After reset, out=1, tx=1, busy=0.

Verification (CLKS_PER_BIT=4, FIFO_DEPTH=4)
REQ-029 Single byte: push 0x55 at cycle 0 -> tx=0 for cycles 2-5, then bits 1,0,1,0,1,0,1,0 for 4 cycles each, then tx=1 for cycles 38-41; busy=0 from cycle 42.
REQ-030 Back-to-back: push 0x41 then 0x42 on consecutive cycles -> second start bit begins exactly 40 cycles after the first; decoded stream is "AB".
REQ-031 Full FIFO: hold valid=1 with bytes 0x01..0x08 -> ready drops once 4 bytes are queued plus 1 in the shifter; all 8 bytes are emitted in order, none lost or repeated.
REQ-032 Ready/valid independence: toggle valid randomly while full -> ready stays 0 and is unaffected by valid; accepted count equals handshake count.
REQ-033 Mid-frame reset: pulse RST_N low for 1 cycle during DATA of 0xA5 with 2 bytes queued -> tx=1 next cycle, busy=0, no further frames, ready=1 after release.
REQ-034 Wrap-around: stream 64 bytes 0x00..0x3F with random valid gaps -> serial output matches the input sequence exactly across repeated pointer wraps.
